// File: rtl/cxu_l2_req_queue_if.sv
// Request/response channel pair of the CXU L2 link.
// The master side issues requests and accepts responses; the slave side is the mirror.
interface cxu_l2_req_queue_if #(
    parameter type cfid_t        = logic [9:0],
    parameter int  CXU_N_CXUS    = 2,
    parameter int  CXU_N_STATES  = 1,
    parameter int  CXU_FUNC_ID_W = $bits(cfid_t),
    parameter int  CXU_DATA_W    = 32,
    parameter int  CXU_REQ_ID_W  = 6
);
    localparam int CXU_ID_W   = (CXU_N_CXUS   > 1) ? $clog2(CXU_N_CXUS)   : 1;
    localparam int STATE_ID_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1;

    logic                     req_valid;
    logic                     req_ready;
    logic [CXU_REQ_ID_W-1:0]  req_id;
    logic [CXU_ID_W-1:0]      req_cxu;
    logic [STATE_ID_W-1:0]    req_state;
    logic [CXU_FUNC_ID_W-1:0] req_func;
    logic [CXU_DATA_W-1:0]    req_data0;
    logic [CXU_DATA_W-1:0]    req_data1;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [2:0]               resp_status;
    logic [CXU_DATA_W-1:0]    resp_data;

    modport master (
        output req_valid, req_id, req_cxu, req_state, req_func, req_data0, req_data1,
        output resp_ready,
        input  req_ready, resp_valid, resp_status, resp_data
    );

    modport slave (
        input  req_valid, req_id, req_cxu, req_state, req_func, req_data0, req_data1,
        input  resp_ready,
        output req_ready, resp_valid, resp_status, resp_data
    );
endinterface

// File: rtl/cxu_l2_req_queue.sv
// CXU L2 request queue: FIFO-buffered request issue with an outstanding-request cap,
// combinational response pass-through and a sticky response-underflow flag.
module cxu_l2_req_queue #(
    parameter type cfid_t        = logic [9:0],
    parameter int  CXU_N_CXUS    = 2,
    parameter int  CXU_N_STATES  = 1,
    parameter int  CXU_FUNC_ID_W = $bits(cfid_t),
    parameter int  CXU_DATA_W    = 32,
    parameter int  CXU_REQ_ID_W  = 6,
    parameter int  DEPTH         = 4,
    parameter int  MAX_OUTST     = 4,
    localparam int OUTST_W       = $clog2(MAX_OUTST + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    cxu_l2_req_queue_if.slave  up,
    cxu_l2_req_queue_if.master dn,
    output logic [OUTST_W-1:0] outst,
    output logic               err
);
    localparam int CXU_ID_W   = (CXU_N_CXUS   > 1) ? $clog2(CXU_N_CXUS)   : 1;
    localparam int STATE_ID_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1;
    localparam int AW         = $clog2(DEPTH);
    localparam int PW         = AW + 1;
    localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTST);

    typedef struct packed {
        logic [CXU_REQ_ID_W-1:0]  id;
        logic [CXU_ID_W-1:0]      cxu;
        logic [STATE_ID_W-1:0]    state;
        logic [CXU_FUNC_ID_W-1:0] func;
        logic [CXU_DATA_W-1:0]    data0;
        logic [CXU_DATA_W-1:0]    data1;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          cap_ok;
    logic          push;
    logic          pop;
    logic          resp_fire;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Ready is deliberately independent of the downstream side: a full FIFO never
    // accepts in the same cycle it pops. rst_n holds it low while reset is asserted.
    assign up.req_ready = rst_n & clk_en & ~full;
    assign push         = up.req_valid & up.req_ready;

    assign dn.resp_ready = up.resp_ready & clk_en;
    assign resp_fire     = dn.resp_valid & dn.resp_ready;

    // A response retiring this cycle frees a slot for an issue in the same cycle.
    assign cap_ok       = (outst < OUTST_MAX) | resp_fire;
    assign dn.req_valid = clk_en & ~empty & cap_ok;
    assign pop          = dn.req_valid & dn.req_ready;

    assign wr_entry = '{id:    up.req_id,
                        cxu:   up.req_cxu,
                        state: up.req_state,
                        func:  up.req_func,
                        data0: up.req_data0,
                        data1: up.req_data1};

    assign head         = mem[rd_ptr[AW-1:0]];
    assign dn.req_id    = head.id;
    assign dn.req_cxu   = head.cxu;
    assign dn.req_state = head.state;
    assign dn.req_func  = head.func;
    assign dn.req_data0 = head.data0;
    assign dn.req_data1 = head.data1;

    assign up.resp_valid  = dn.resp_valid;
    assign up.resp_status = dn.resp_status;
    assign up.resp_data   = dn.resp_data;

    // NOTE: storage has no reset; validity is tracked by the pointers alone, and
    // leaving it out of reset keeps it a plain RAM-style register array.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // push, pop and resp_fire all include clk_en, so nothing moves when it is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            outst  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (resp_fire && (outst == '0)) begin
                err <= 1'b1;
            end
            if (pop && !resp_fire) begin
                outst <= outst + OUTST_W'(1);
            end else if (!pop && resp_fire && (outst != '0)) begin
                outst <= outst - OUTST_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cxu_l2_req_queue.sv
// Self-checking bench for cxu_l2_req_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_cxu_l2_req_queue;
    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;

    typedef struct packed {
        logic [5:0]  id;
        logic        cxu;
        logic        state;
        logic [9:0]  func;
        logic [31:0] data0;
        logic [31:0] data1;
    } req_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic [1:0] outst;
    logic       err;

    cxu_l2_req_queue_if up_if ();
    cxu_l2_req_queue_if dn_if ();

    cxu_l2_req_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .up     (up_if),
        .dn     (dn_if),
        .outst  (outst),
        .err    (err)
    );

    always #5 clk = ~clk;

    req_t model_q[$];
    int   m_outst;
    bit   m_err;
    int   n_checks;
    int   n_pass;
    int   issued_ids[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic req_t mk(input int id, input int d0, input int d1);
        req_t r;
        r       = '0;
        r.id    = 6'(id);
        r.data0 = 32'(d0);
        r.data1 = 32'(d1);
        return r;
    endfunction

    task automatic drive_req(input bit v, input req_t r);
        up_if.req_valid = v;
        up_if.req_id    = r.id;
        up_if.req_cxu   = r.cxu;
        up_if.req_state = r.state;
        up_if.req_func  = r.func;
        up_if.req_data0 = r.data0;
        up_if.req_data1 = r.data1;
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit   exp_rr, exp_tv, exp_fire, do_push, do_pop;
        req_t cur, head_obs;
        @(negedge clk);
        exp_fire = clk_en && dn_if.resp_valid && up_if.resp_ready;
        exp_rr   = clk_en && (model_q.size() < DEPTH);
        exp_tv   = clk_en && (model_q.size() > 0) && ((m_outst < MAX_OUTST) || exp_fire);
        check("req_ready", up_if.req_ready, exp_rr);
        check("t_req_valid", dn_if.req_valid, exp_tv);
        check("t_resp_ready", dn_if.resp_ready, up_if.resp_ready && clk_en);
        check("outst", outst, m_outst);
        check("err", err, m_err);
        check("resp_valid", up_if.resp_valid, dn_if.resp_valid);
        check("resp_data", up_if.resp_data, dn_if.resp_data);
        check("resp_status", up_if.resp_status, dn_if.resp_status);
        if (exp_tv) begin
            head_obs = '{id: dn_if.req_id, cxu: dn_if.req_cxu, state: dn_if.req_state,
                         func: dn_if.req_func, data0: dn_if.req_data0, data1: dn_if.req_data1};
            check("t_req_head", head_obs, model_q[0]);
        end
        cur = '{id: up_if.req_id, cxu: up_if.req_cxu, state: up_if.req_state,
                func: up_if.req_func, data0: up_if.req_data0, data1: up_if.req_data1};
        do_push = up_if.req_valid && exp_rr;
        do_pop  = exp_tv && dn_if.req_ready;
        if (do_pop) issued_ids.push_back(int'(dn_if.req_id));
        @(posedge clk);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(cur);
        if (exp_fire && m_outst == 0) m_err = 1'b1;
        if (do_pop && !exp_fire) m_outst++;
        else if (!do_pop && exp_fire && m_outst > 0) m_outst--;
        #1;
    endtask

    task automatic do_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        check("rst_t_req_valid", dn_if.req_valid, 1'b0);
        check("rst_outst", outst, 2'd0);
        check("rst_req_ready", up_if.req_ready, 1'b0);
        check("rst_err", err, 1'b0);
        model_q.delete();
        m_outst = 0;
        m_err   = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_outst  = 0;
        m_err    = 1'b0;
        rst_n    = 1'b1;
        clk_en   = 1'b1;
        drive_req(1'b0, '0);
        up_if.resp_ready  = 1'b1;
        dn_if.req_ready   = 1'b0;
        dn_if.resp_valid  = 1'b0;
        dn_if.resp_status = 3'd0;
        dn_if.resp_data   = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("reset_req_ready", up_if.req_ready, 1'b0);
        check("reset_t_req_valid", dn_if.req_valid, 1'b0);
        check("reset_outst", outst, 2'd0);
        check("reset_err", err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single operation
        drive_req(1'b1, mk(5, 3, 4));
        dn_if.req_ready = 1'b1;
        cycle();
        drive_req(1'b0, '0);
        check("single_t_req_valid", dn_if.req_valid, 1'b1);
        check("single_id", dn_if.req_id, 6'd5);
        check("single_data0", dn_if.req_data0, 32'd3);
        cycle();
        check("single_outst_1", outst, 2'd1);
        dn_if.resp_valid  = 1'b1;
        dn_if.resp_data   = 32'd7;
        dn_if.resp_status = 3'd1;
        #1;
        check("single_resp_data", up_if.resp_data, 32'd7);
        cycle();
        dn_if.resp_valid = 1'b0;
        check("single_outst_0", outst, 2'd0);

        // Fill / backpressure, then in-order issue
        dn_if.req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b1, mk(i, 100 + i, 200 + i));
            cycle();
        end
        drive_req(1'b0, '0);
        check("fill_req_ready", up_if.req_ready, 1'b0);
        issued_ids.delete();
        dn_if.req_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            dn_if.resp_valid = (m_outst > 0);
            cycle();
        end
        dn_if.resp_valid = 1'b0;
        check("order_count", issued_ids.size(), 4);
        for (int i = 0; i < 4; i++) check("order_id", issued_ids[i], i);

        // Outstanding cap
        dn_if.req_ready = 1'b0;
        for (int i = 10; i < 14; i++) begin
            drive_req(1'b1, mk(i, i, i));
            cycle();
        end
        drive_req(1'b0, '0);
        issued_ids.delete();
        dn_if.req_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("cap_issues", issued_ids.size(), 2);
        check("cap_t_req_valid", dn_if.req_valid, 1'b0);
        check("cap_outst", outst, 2'd2);
        dn_if.resp_valid = 1'b1;
        #1;
        check("cap_issue_on_resp", dn_if.req_valid, 1'b1);
        cycle();
        dn_if.resp_valid = 1'b0;
        check("cap_outst_hold", outst, 2'd2);

        // Full FIFO: push attempt plus pop -> only the pop
        dn_if.req_ready  = 1'b0;
        dn_if.resp_valid = 1'b1;
        cycle();
        cycle();
        dn_if.resp_valid = 1'b0;
        for (int i = 20; i < 23; i++) begin
            drive_req(1'b1, mk(i, i, i));
            cycle();
        end
        check("full_req_ready", up_if.req_ready, 1'b0);
        drive_req(1'b1, mk(23, 23, 23));
        dn_if.req_ready = 1'b1;
        cycle();
        drive_req(1'b0, '0);
        dn_if.req_ready = 1'b0;
        #1;
        check("full_pop_ready", up_if.req_ready, 1'b1);
        check("full_pop_head", dn_if.req_id, 6'd20);

        // Underflow
        dn_if.resp_valid = 1'b1;
        cycle();
        check("pre_underflow_outst", outst, 2'd0);
        cycle();
        dn_if.resp_valid = 1'b0;
        check("underflow_err", err, 1'b1);
        check("underflow_outst", outst, 2'd0);
        cycle();
        check("underflow_err_sticky", err, 1'b1);

        // Reset mid-operation with 3 queued and 2 outstanding
        dn_if.req_ready = 1'b1;
        cycle();
        cycle();
        dn_if.req_ready = 1'b0;
        drive_req(1'b1, mk(30, 30, 30));
        cycle();
        drive_req(1'b1, mk(31, 31, 31));
        cycle();
        drive_req(1'b0, '0);
        check("pre_reset_outst", outst, 2'd2);
        do_reset_mid();
        dn_if.resp_valid = 1'b1;
        cycle();
        dn_if.resp_valid = 1'b0;
        check("post_reset_resp_err", err, 1'b1);
        do_reset_mid();

        // First push on the first edge after reset, then clk_en low holds everything
        drive_req(1'b1, mk(40, 1, 2));
        cycle();
        drive_req(1'b0, '0);
        clk_en = 1'b0;
        drive_req(1'b1, mk(41, 5, 6));
        dn_if.req_ready  = 1'b1;
        dn_if.resp_valid = 1'b1;
        #1;
        check("clken_req_ready", up_if.req_ready, 1'b0);
        check("clken_t_req_valid", dn_if.req_valid, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        clk_en = 1'b1;
        drive_req(1'b0, '0);
        dn_if.resp_valid = 1'b0;
        check("clken_outst", outst, 2'd0);
        check("clken_err", err, 1'b0);
        check("clken_head", dn_if.req_id, 6'd40);
        cycle();
        check("clken_issue_outst", outst, 2'd1);

        // Random traffic
        do_reset_mid();
        for (int i = 0; i < 400; i++) begin
            req_t r;
            r.id    = 6'($urandom);
            r.cxu   = 1'($urandom);
            r.state = 1'($urandom);
            r.func  = 10'($urandom);
            r.data0 = $urandom;
            r.data1 = $urandom;
            clk_en = ($urandom_range(0, 9) != 0);
            drive_req(1'($urandom_range(0, 1)), r);
            dn_if.req_ready   = 1'($urandom_range(0, 1));
            up_if.resp_ready  = ($urandom_range(0, 3) != 0);
            dn_if.resp_valid  = (m_outst > 0) && ($urandom_range(0, 2) == 0);
            dn_if.resp_status = 3'($urandom);
            dn_if.resp_data   = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
